full_adder_1_bit: RTL and testbench
===================================

FULL_ADDER_1_BIT -- requirements
Module: full_adder_1_bit

Interface
REQ-001 Parameter CARRY_INIT, default 1'b0: value loaded into the serial carry register at reset.
REQ-002 Port clk, input, 1: single rising-edge clock for all state.
REQ-003 Port rst, input, 1: synchronous, active-high reset.
REQ-004 Port a, input, 1: addend bit.
REQ-005 Port b, input, 1: addend bit.
REQ-006 Port cin, input, 1: external carry-in.
REQ-007 Port ser_mode, input, 1: 0 = plain adder (carry from cin); 1 = serial adder (carry from internal register).
REQ-008 Port start, input, 1: in serial mode, first bit of a new word; carry taken from cin this cycle.
REQ-009 Port en, input, 1: capture strobe for registered outputs and the carry register.
REQ-010 Port sum, output, 1: combinational sum bit.
REQ-011 Port cout, output, 1: combinational carry-out.
REQ-012 Port sum_q, output, 1: registered sum.
REQ-013 Port cout_q, output, 1: registered carry-out.
REQ-014 Port valid_q, output, 1: high for exactly the one cycle after an en capture.

Function
REQ-015 Effective carry c_eff SHALL be:
- cin when ser_mode=0 or start=1;
- otherwise the carry register.
REQ-016 sum SHALL equal a XOR b XOR c_eff, zero latency, with no dependence on clk or rst.
REQ-017 cout SHALL equal (a AND b) OR (c_eff AND (a XOR b)), zero latency.
REQ-018 With ser_mode=0, sum/cout SHALL be the full truth table of a, b, cin for all 8 input combinations, independent of clk activity.
REQ-019 On a rising clk with en=1 and rst=0, the block SHALL:
- load sum_q<=sum and cout_q<=cout;
- set valid_q<=1;
- load the carry register <= cout.
REQ-020 On a rising clk with en=0 and rst=0, the block SHALL:
- hold sum_q, cout_q and the carry register;
- set valid_q<=0.
REQ-021 Serial mode SHALL:
- add LSB-first bit streams, one bit per en cycle;
- restart the carry chain on start=1 (start with en=0 has no effect on state).
REQ-022 When ser_mode changes, the carry register SHALL keep its value; it is ignored while ser_mode=0.
REQ-023 Registered output latency SHALL be 1 clock from the en capture edge.

Reset
REQ-024 When rst=1 at a rising clk edge, the block SHALL set sum_q=0, cout_q=0, valid_q=0 and carry register=CARRY_INIT.
REQ-025 Reset SHALL take priority over en and start.
REQ-026 A reset mid-word SHALL abandon the serial word; the next word SHALL begin with start=1.
REQ-027 Reset SHALL have no effect on the combinational outputs sum and cout.

Structure
REQ-028 The design SHALL contain one sub-module, half_adder (ports x, y, s, c).
REQ-029 full_adder_1_bit SHALL instantiate half_adder twice, plus an OR gate for cout.
REQ-030 No shared package is required; CARRY_INIT is the only constant and is a module parameter.
REQ-031 Registers SHALL reside only in full_adder_1_bit, in a single clocked process.

Verification
REQ-032 Combinational test, with ser_mode=0 and cin=0:
- a,b = 00 -> sum=0, cout=0;
- a,b = 01 -> sum=1, cout=0;
- a,b = 10 -> sum=1, cout=0;
- a,b = 11 -> sum=0, cout=1.
- Outputs SHALL be checked 10 ns after each change, with no clock running.
REQ-033 Exhaustive test: all 8 combinations of a, b, cin with ser_mode=0 -> sum = parity of the three inputs, cout = majority of the three inputs.
REQ-034 Serial test, ser_mode=1, 0110 + 0011, LSB first:
- start=1 on bit 0, en=1 for 4 cycles;
- sum_q sequence SHALL be 1,0,0,1 (result 1001);
- final cout_q SHALL be 0.
REQ-035 Reset test: rst=1 for one edge while en=1 with a=b=cin=1 -> sum_q=0, cout_q=0, valid_q=0, carry register=0 on the next cycle.
REQ-036 Hold test: capture with en=1, then en=0 for 3 cycles while the inputs toggle -> sum_q and cout_q unchanged, valid_q=0 after the first hold cycle.

Source files
------------

// File: rtl/half_adder.sv
// Half adder: the basic propagate/generate cell.
// s is the XOR of the two inputs, c is their AND. Purely combinational.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

// File: rtl/full_adder_1_bit.sv
// One-bit full adder with registered outputs and an optional serial mode.
//
// Plain mode (ser_mode=0):
//   - The carry-in comes from cin.
//
// Serial mode (ser_mode=1):
//   - The carry comes from an internal carry register, so that LSB-first
//     bit streams can be added one bit per en cycle.
//   - start=1 marks the first bit of a word. On that bit the carry is taken
//     from cin instead, which restarts the chain.
//
// The combinational sum/cout never depend on clk or rst. Every register lives
// in the single clocked process at the bottom of this file.
module full_adder_1_bit #(
  parameter logic CARRY_INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic ser_mode,
  input  logic start,
  input  logic en,
  output logic sum,
  output logic cout,
  output logic sum_q,
  output logic cout_q,
  output logic valid_q
);

  logic c_eff;
  logic prop;
  logic gen0;
  logic gen1;

  logic carry_q;
  logic carry_d;
  logic sum_d;
  logic cout_d;
  logic valid_d;

  // Choose the carry: cin in plain mode or on a word start, otherwise the
  // carry register.
  always_comb begin
    c_eff = cin;
    if (ser_mode && !start) begin
      c_eff = carry_q;
    end else begin
      c_eff = cin;
    end
  end

  // First half adder: propagate (a^b) and generate (a&b).
  half_adder u_ha0 (
    .x (a),
    .y (b),
    .s (prop),
    .c (gen0)
  );

  // Second half adder: fold the effective carry into the propagate term.
  half_adder u_ha1 (
    .x (prop),
    .y (c_eff),
    .s (sum),
    .c (gen1)
  );

  assign cout = gen0 | gen1;

  // Next-state logic.
  // en captures the current sum/cout and chains the carry forward.
  // Without en, every register holds its value except valid, which drops.
  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    carry_d = carry_q;
    valid_d = 1'b0;
    if (en) begin
      sum_d   = sum;
      cout_d  = cout;
      carry_d = cout;
      valid_d = 1'b1;
    end else begin
      valid_d = 1'b0;
    end
  end

  // State register. The synchronous reset wins over en and start, so any
  // serial word in progress is abandoned.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= 1'b0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
      carry_q <= CARRY_INIT;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_full_adder_1_bit.sv
// Self-checking bench for full_adder_1_bit.
//
// A word-level arithmetic model is updated on each rising edge. A negedge
// process compares every DUT output against that model. Directed sequences
// add hand-computed literal expectations on top.
module tb_full_adder_1_bit;

  logic clk;
  logic rst;
  logic a;
  logic b;
  logic cin;
  logic ser_mode;
  logic start;
  logic en;
  logic sum;
  logic cout;
  logic sum_q;
  logic cout_q;
  logic valid_q;

  int total = 0;
  int bad   = 0;

  logic clk_run = 1'b0;
  logic chk_on  = 1'b0;

  // Reference model state: carry register and registered outputs.
  int m_carry;
  int m_sum;
  int m_cout;
  int m_valid;

  full_adder_1_bit #(.CARRY_INIT(1'b0)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .ser_mode (ser_mode),
    .start    (start),
    .en       (en),
    .sum      (sum),
    .cout     (cout),
    .sum_q    (sum_q),
    .cout_q   (cout_q),
    .valid_q  (valid_q)
  );

  // Clock runs only once clk_run is raised, so the first phase is clock-free.
  initial clk = 1'b0;
  always begin
    wait (clk_run);
    #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: integer sum of the three bits gives parity (sum) and majority (cout).
  function automatic int model_total(input logic ser, input logic st, input int carry,
                                     input logic ai, input logic bi, input logic ci);
    int c;
    c = (ser && !st) ? carry : int'(ci);
    return int'(ai) + int'(bi) + c;
  endfunction

  // Model update on the active edge.
  always @(posedge clk) begin
    int t;
    t = model_total(ser_mode, start, m_carry, a, b, cin);
    if (rst) begin
      m_sum = 0; m_cout = 0; m_valid = 0; m_carry = 0;
    end else if (en) begin
      m_sum = t % 2; m_cout = t / 2; m_valid = 1; m_carry = t / 2;
    end else begin
      m_valid = 0;
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    int t;
    if (chk_on) begin
      t = model_total(ser_mode, start, m_carry, a, b, cin);
      chk("cyc_sum",     sum,     logic'(t % 2));
      chk("cyc_cout",    cout,    logic'(t / 2));
      chk("cyc_sum_q",   sum_q,   logic'(m_sum));
      chk("cyc_cout_q",  cout_q,  logic'(m_cout));
      chk("cyc_valid_q", valid_q, logic'(m_valid));
    end
  end

  task automatic drive(input logic ai, input logic bi, input logic ci,
                       input logic ser, input logic st, input logic e);
    a = ai; b = bi; cin = ci; ser_mode = ser; start = st; en = e;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_half [4];
  logic [3:0] word_a;
  logic [3:0] word_b;
  logic [4:0] word_sum;
  logic [3:0] got_word;
  logic [3:0] ser_exp;

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Combinational phase: no clock running, cin=0, checked 10 ns after each change.
    // Each entry packs {a, b, sum, cout}.
    exp_half[0] = 4'b0000;
    exp_half[1] = 4'b0110;
    exp_half[2] = 4'b1010;
    exp_half[3] = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] v;
      v = exp_half[i];
      drive(v[3], v[2], 1'b0, 1'b0, 1'b0, 1'b0);
      #10;
      chk("comb_sum",  sum,  v[1]);
      chk("comb_cout", cout, v[0]);
    end

    // Exhaustive truth table: sum is parity, cout is majority.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      int ones;
      v = i[2:0];
      ones = int'(v[2]) + int'(v[1]) + int'(v[0]);
      drive(v[2], v[1], v[0], 1'b0, 1'b0, 1'b0);
      #10;
      chk("exh_sum",  sum,  logic'(ones % 2));
      chk("exh_cout", cout, logic'(ones >= 2));
    end

    // Clocked phase: the first edge applies reset.
    clk_run = 1'b1;
    step();
    rst = 1'b0;
    chk_on = 1'b1;
    chk("rst_sum_q",   sum_q,   1'b0);
    chk("rst_cout_q",  cout_q,  1'b0);
    chk("rst_valid_q", valid_q, 1'b0);

    // Serial word: 0110 + 0011, LSB first. Expected sum bits are 1,0,0,1 with final carry 0.
    word_a   = 4'b0110;
    word_b   = 4'b0011;
    ser_exp  = 4'b1001;
    word_sum = {1'b0, word_a} + {1'b0, word_b};
    got_word = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      drive(word_a[i], word_b[i], 1'b0, 1'b1, (i == 0), 1'b1);
      step();
      chk("ser_bit",   sum_q,   ser_exp[i]);
      chk("ser_valid", valid_q, 1'b1);
      got_word[i] = sum_q;
    end
    total++;
    if (got_word !== word_sum[3:0]) begin
      bad++;
      $display("FAIL ser_word actual=%b expected=%b", got_word, word_sum[3:0]);
    end
    chk("ser_cout_q", cout_q, 1'b0);
    chk("ser_cout_w", cout_q, word_sum[4]);

    // The carry register survives a ser_mode change and is ignored in plain mode.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    chk("mode_cap_cout_q", cout_q, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("mode_plain_sum", sum, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("mode_kept_carry", sum, 1'b1);

    // A start strobe without en leaves the carry register untouched.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("start_no_en", sum, 1'b1);

    // Reset during en with a=b=cin=1, while the carry register holds 1.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_sum_q",   sum_q,   1'b0);
    chk("rst2_cout_q",  cout_q,  1'b0);
    chk("rst2_valid_q", valid_q, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("rst2_carry", sum, 1'b0);

    // Hold: capture 1+1+0, then three en=0 cycles while the inputs toggle.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("hold_cap_sum_q",  sum_q,   1'b0);
    chk("hold_cap_cout_q", cout_q,  1'b1);
    chk("hold_cap_valid",  valid_q, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(logic'(i % 2), logic'((i + 1) % 2), logic'(i == 1), 1'b0, 1'b0, 1'b0);
      step();
      chk("hold_sum_q",  sum_q,   1'b0);
      chk("hold_cout_q", cout_q,  1'b1);
      chk("hold_valid",  valid_q, 1'b0);
    end

    step();
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
